// File: rtl/vga_pkg.sv
// Shared VGA timing presets, pipeline latency helper and {b,g,r} packing offsets.
package vga_pkg;

  typedef struct packed {
    int unsigned h_active;
    int unsigned h_fp;
    int unsigned h_sync;
    int unsigned h_bp;
    int unsigned v_active;
    int unsigned v_fp;
    int unsigned v_sync;
    int unsigned v_bp;
  } vga_timing_t;

  localparam vga_timing_t TIMING_640X480 = '{640, 16, 96, 48, 480, 10, 2, 33};
  localparam vga_timing_t TIMING_800X600 = '{800, 40, 128, 88, 600, 1, 4, 23};

  localparam int unsigned R_OFS = 0;
  localparam int unsigned G_OFS = 8;
  localparam int unsigned B_OFS = 16;

  // Sideband travelling alongside each pixel, stored at pin level.
  typedef struct packed {
    logic hs;
    logic vs;
    logic blank_n;
    logic frame;
  } ctrl_t;

  function automatic int unsigned pipe_latency(input int unsigned mem_lat);
    return mem_lat + 2;
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Raster counters with active/sync decode and line-end / frame strobes.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int unsigned HW      = $clog2(H_TOTAL),
  localparam int unsigned VW      = $clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          reset,
  output logic [HW-1:0] hcnt,
  output logic [VW-1:0] vcnt,
  output logic          active,
  output logic          hsync,
  output logic          vsync,
  output logic          line_end,
  output logic          frame_start,
  output logic          frame_end
);

  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic          h_last, v_last;

  assign h_last = (32'(hcnt_q) == H_TOTAL - 1);
  assign v_last = (32'(vcnt_q) == V_TOTAL - 1);

  always_comb begin
    hcnt_d = hcnt_q + HW'(1);
    vcnt_d = vcnt_q;
    if (h_last) begin
      hcnt_d = '0;
      vcnt_d = v_last ? '0 : vcnt_q + VW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

  assign hcnt        = hcnt_q;
  assign vcnt        = vcnt_q;
  assign active      = (32'(hcnt_q) < H_ACTIVE) && (32'(vcnt_q) < V_ACTIVE);
  assign hsync       = (32'(hcnt_q) >= H_ACTIVE + H_FP) && (32'(hcnt_q) < H_ACTIVE + H_FP + H_SYNC);
  assign vsync       = (32'(vcnt_q) >= V_ACTIVE + V_FP) && (32'(vcnt_q) < V_ACTIVE + V_FP + V_SYNC);
  assign line_end    = active && (32'(hcnt_q) == H_ACTIVE - 1);
  assign frame_start = (hcnt_q == '0) && (vcnt_q == '0);
  assign frame_end   = h_last && v_last;

endmodule

// File: rtl/vga_scan_engine.sv
// Raster scan engine: framebuffer address generation with 2^n replication,
// palette lookup and a sideband pipeline aligned to the RGB outputs.
module vga_scan_engine import vga_pkg::*; #(
  parameter int unsigned H_ACTIVE    = TIMING_640X480.h_active,
  parameter int unsigned H_FP        = TIMING_640X480.h_fp,
  parameter int unsigned H_SYNC      = TIMING_640X480.h_sync,
  parameter int unsigned H_BP        = TIMING_640X480.h_bp,
  parameter int unsigned V_ACTIVE    = TIMING_640X480.v_active,
  parameter int unsigned V_FP        = TIMING_640X480.v_fp,
  parameter int unsigned V_SYNC      = TIMING_640X480.v_sync,
  parameter int unsigned V_BP        = TIMING_640X480.v_bp,
  parameter bit          HS_POL      = 1'b0,
  parameter bit          VS_POL      = 1'b0,
  parameter int unsigned SCALE_SHIFT = 0,
  parameter int unsigned ADDR_W      = 19,
  parameter int unsigned IDX_W       = 8,
  parameter int unsigned MEM_LAT     = 2
) (
  input  logic              iVGA_CLK,
  input  logic              reset,
  output logic [ADDR_W-1:0] fb_addr,
  output logic              fb_rd_en,
  input  logic [IDX_W-1:0]  fb_index,
  input  logic              pal_wr_en,
  input  logic [IDX_W-1:0]  pal_wr_addr,
  input  logic [23:0]       pal_wr_data,
  output logic              oHS,
  output logic              oVS,
  output logic              oBLANK_n,
  output logic [7:0]        r_data,
  output logic [7:0]        g_data,
  output logic [7:0]        b_data,
  output logic              oFrame
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW       = $clog2(H_TOTAL);
  localparam int unsigned VW       = $clog2(V_TOTAL);
  localparam int unsigned L        = pipe_latency(MEM_LAT);
  localparam int unsigned SRC_W    = H_ACTIVE >> SCALE_SHIFT;
  localparam int unsigned V_SRC    = V_ACTIVE >> SCALE_SHIFT;
  localparam int unsigned REP_MASK = (1 << SCALE_SHIFT) - 1;
  localparam ctrl_t CTRL_IDLE = '{hs: ~HS_POL, vs: ~VS_POL, blank_n: 1'b0, frame: 1'b0};

  if ((H_ACTIVE % (1 << SCALE_SHIFT)) != 0 || (V_ACTIVE % (1 << SCALE_SHIFT)) != 0) begin : g_bad_scale
    $error("vga_scan_engine: active area not divisible by replication factor");
  end
  if ((64'(SRC_W) * 64'(V_SRC)) > (64'd1 << ADDR_W)) begin : g_bad_addr_w
    $error("vga_scan_engine: source framebuffer does not fit in ADDR_W");
  end
  if (MEM_LAT < 1) begin : g_bad_mem_lat
    $error("vga_scan_engine: MEM_LAT must be at least 1");
  end

  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic          active, hsync, vsync, line_end, frame_start, frame_end;

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
  ) u_timing (
    .clk         (iVGA_CLK),
    .reset       (reset),
    .hcnt        (hcnt),
    .vcnt        (vcnt),
    .active      (active),
    .hsync       (hsync),
    .vsync       (vsync),
    .line_end    (line_end),
    .frame_start (frame_start),
    .frame_end   (frame_end)
  );

  logic [ADDR_W-1:0] line_base_q, line_base_d;
  logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
  logic              fb_rd_en_q, fb_rd_en_d;
  logic [23:0]       pal_rd_q, pal_rd_d;
  logic [23:0]       rgb_q, rgb_d;
  ctrl_t             ctrl_q [0:L];
  ctrl_t             ctrl_d [0:L];
  logic [23:0]       pal_ram [2**IDX_W];

  // line_base only advances after the last repeat of a source row.
  always_comb begin
    line_base_d = line_base_q;
    if (frame_end) begin
      line_base_d = '0;
    end else if (line_end && ((32'(vcnt) & REP_MASK) == REP_MASK)) begin
      line_base_d = line_base_q + ADDR_W'(SRC_W);
    end
    fb_addr_d  = line_base_q + ADDR_W'(hcnt >> SCALE_SHIFT);
    fb_rd_en_d = active;
    pal_rd_d   = pal_ram[fb_index];
    rgb_d      = ctrl_q[L-1].blank_n ? pal_rd_q : 24'h0;
    ctrl_d[0]  = '{hs:      hsync ? HS_POL : ~HS_POL,
                   vs:      vsync ? VS_POL : ~VS_POL,
                   blank_n: active,
                   frame:   frame_start};
    for (int i = 1; i <= int'(L); i++) begin
      ctrl_d[i] = ctrl_q[i-1];
    end
  end

  always_ff @(posedge iVGA_CLK) begin
    if (reset) begin
      line_base_q <= '0;
      fb_addr_q   <= '0;
      fb_rd_en_q  <= 1'b0;
      pal_rd_q    <= '0;
      rgb_q       <= '0;
      for (int i = 0; i <= int'(L); i++) begin
        ctrl_q[i] <= CTRL_IDLE;
      end
    end else begin
      line_base_q <= line_base_d;
      fb_addr_q   <= fb_addr_d;
      fb_rd_en_q  <= fb_rd_en_d;
      pal_rd_q    <= pal_rd_d;
      rgb_q       <= rgb_d;
      for (int i = 0; i <= int'(L); i++) begin
        ctrl_q[i] <= ctrl_d[i];
      end
    end
  end

  // Palette contents survive reset; a same-cycle read sees the previous value.
  always_ff @(posedge iVGA_CLK) begin
    if (pal_wr_en) begin
      pal_ram[pal_wr_addr] <= pal_wr_data;
    end
  end

  assign fb_addr  = fb_addr_q;
  assign fb_rd_en = fb_rd_en_q;
  assign oHS      = ctrl_q[L].hs;
  assign oVS      = ctrl_q[L].vs;
  assign oBLANK_n = ctrl_q[L].blank_n;
  assign oFrame   = ctrl_q[L].frame;
  assign r_data   = rgb_q[R_OFS +: 8];
  assign g_data   = rgb_q[G_OFS +: 8];
  assign b_data   = rgb_q[B_OFS +: 8];

endmodule

// File: tb/tb_vga_scan_engine.sv
// Directed bench for vga_scan_engine on a reduced 24x12 raster, 2x replication, MEM_LAT=3.
module tb_vga_scan_engine;

  localparam int unsigned LAT = 3;
  localparam int          L   = LAT + 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  fb_addr;
  logic        fb_rd_en;
  logic [7:0]  fb_index;
  logic        pal_wr_en = 1'b0;
  logic [7:0]  pal_wr_addr = '0;
  logic [23:0] pal_wr_data = '0;
  logic        oHS, oVS, oBLANK_n, oFrame;
  logic [7:0]  r_data, g_data, b_data;
  logic [23:0] rgb;
  logic        idx_zero = 1'b0;
  logic [7:0]  mem_pipe [LAT];

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int t = 0;
  int cnt_vis, cnt_hs, cnt_vs, cnt_bad, cnt_white, last_fall, period;
  logic prev_hs;

  vga_scan_engine #(
    .H_ACTIVE (16), .H_FP (2), .H_SYNC (3), .H_BP (3),
    .V_ACTIVE (8),  .V_FP (1), .V_SYNC (2), .V_BP (1),
    .HS_POL (1'b0), .VS_POL (1'b1),
    .SCALE_SHIFT (1), .ADDR_W (8), .IDX_W (8), .MEM_LAT (LAT)
  ) dut (
    .iVGA_CLK    (clk),
    .reset       (reset),
    .fb_addr     (fb_addr),
    .fb_rd_en    (fb_rd_en),
    .fb_index    (fb_index),
    .pal_wr_en   (pal_wr_en),
    .pal_wr_addr (pal_wr_addr),
    .pal_wr_data (pal_wr_data),
    .oHS         (oHS),
    .oVS         (oVS),
    .oBLANK_n    (oBLANK_n),
    .r_data      (r_data),
    .g_data      (g_data),
    .b_data      (b_data),
    .oFrame      (oFrame)
  );

  always #5 clk = ~clk;

  // Framebuffer: index = addr, delivered LAT cycles after the address.
  always @(posedge clk) begin
    mem_pipe[0] <= fb_addr;
    for (int i = 1; i < int'(LAT); i++) mem_pipe[i] <= mem_pipe[i-1];
  end
  assign fb_index = idx_zero ? 8'h00 : mem_pipe[LAT-1];
  assign rgb      = {b_data, g_data, r_data};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic run_to(input int target);
    while (t < target) tick();
  endtask

  task automatic chk_reset_state(input string pfx);
    chk({pfx, "_fb_addr"}, 32'(fb_addr), 32'h0);
    chk({pfx, "_fb_rd_en"}, 32'(fb_rd_en), 32'h0);
    chk({pfx, "_hs"}, 32'(oHS), 32'h1);
    chk({pfx, "_vs"}, 32'(oVS), 32'h0);
    chk({pfx, "_blank_n"}, 32'(oBLANK_n), 32'h0);
    chk({pfx, "_rgb"}, 32'(rgb), 32'h0);
    chk({pfx, "_frame"}, 32'(oFrame), 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Palette i = {b=i, g=~i, r=i}, loaded while reset is held.
    @(posedge clk); #1;
    for (int i = 0; i < 256; i++) begin
      pal_wr_en   = 1'b1;
      pal_wr_addr = 8'(i);
      pal_wr_data = {8'(i), ~8'(i), 8'(i)};
      @(posedge clk); #1;
    end
    pal_wr_en = 1'b0;
    chk_reset_state("rst");

    // t counts edges after release; fb_addr at t is raster position t, pins show t-L.
    reset = 1'b0;
    t = -1;
    run_to(0);
    chk("t0_fb_addr", 32'(fb_addr), 32'd0);
    chk("t0_rd_en", 32'(fb_rd_en), 32'd1);
    run_to(1);  chk("t1_fb_addr_rep", 32'(fb_addr), 32'd0);
    run_to(2);  chk("t2_fb_addr", 32'(fb_addr), 32'd1);
    run_to(4);
    chk("pre_frame", 32'(oFrame), 32'd0);
    chk("pre_blank_n", 32'(oBLANK_n), 32'd0);
    chk("pre_rgb", 32'(rgb), 32'h0);
    run_to(5);
    chk("frame_pulse", 32'(oFrame), 32'd1);
    chk("first_blank_n", 32'(oBLANK_n), 32'd1);
    chk("first_rgb", 32'(rgb), 32'h00FF00);
    run_to(6);  chk("frame_one_cycle", 32'(oFrame), 32'd0);
    run_to(7);  chk("pix2_rgb", 32'(rgb), 32'h01FE01);
    run_to(15); chk("line0_last_addr", 32'(fb_addr), 32'd7);
    run_to(16); chk("line0_rd_off", 32'(fb_rd_en), 32'd0);
    run_to(21);
    chk("hblank_blank_n", 32'(oBLANK_n), 32'd0);
    chk("hblank_rgb", 32'(rgb), 32'h0);
    run_to(22); chk("hs_before", 32'(oHS), 32'd1);
    run_to(23); chk("hs_start", 32'(oHS), 32'd0);
    run_to(24);
    chk("line1_addr", 32'(fb_addr), 32'd0);
    chk("line1_rd_en", 32'(fb_rd_en), 32'd1);
    run_to(25); chk("hs_last", 32'(oHS), 32'd0);
    run_to(26); chk("hs_end", 32'(oHS), 32'd1);
    run_to(48); chk("line2_addr", 32'(fb_addr), 32'd8);
    run_to(183);
    chk("last_addr", 32'(fb_addr), 32'd31);
    chk("last_rd_en", 32'(fb_rd_en), 32'd1);
    run_to(192); chk("vblank_rd_off", 32'(fb_rd_en), 32'd0);
    run_to(220); chk("vs_before", 32'(oVS), 32'd0);
    run_to(221); chk("vs_start", 32'(oVS), 32'd1);
    run_to(268); chk("vs_last", 32'(oVS), 32'd1);
    run_to(269); chk("vs_end", 32'(oVS), 32'd0);
    run_to(287); chk("frame_last_rd_en", 32'(fb_rd_en), 32'd0);
    run_to(288);
    chk("wrap_addr", 32'(fb_addr), 32'd0);
    chk("wrap_rd_en", 32'(fb_rd_en), 32'd1);
    run_to(292); chk("frame2_pre", 32'(oFrame), 32'd0);
    run_to(293); chk("frame2_pulse", 32'(oFrame), 32'd1);

    // Whole second frame at the pins: sync widths, period and visible count.
    cnt_vis = 0; cnt_hs = 0; cnt_vs = 0; last_fall = -1; period = 0;
    prev_hs = oHS;
    while (t <= 580) begin
      if (oBLANK_n) cnt_vis++;
      if (!oHS) cnt_hs++;
      if (oVS) cnt_vs++;
      if (prev_hs && !oHS) begin
        if (last_fall >= 0) period = t - last_fall;
        last_fall = t;
      end
      prev_hs = oHS;
      tick();
    end
    chk("frame_vis_count", 32'(cnt_vis), 32'd128);
    chk("frame_hs_low", 32'(cnt_hs), 32'd36);
    chk("frame_vs_high", 32'(cnt_vs), 32'd48);
    chk("hs_period", 32'(period), 32'd24);

    // Entry 5 rewritten in the same cycle the h=10 pixel reads it.
    run_to(589);
    pal_wr_en   = 1'b1;
    pal_wr_addr = 8'd5;
    pal_wr_data = 24'h00FF00;
    tick();
    pal_wr_en = 1'b0;
    chk("pix9_untouched", 32'(rgb), 32'h04FB04);
    run_to(591); chk("same_cycle_old", 32'(rgb), 32'h05FA05);
    run_to(592); chk("next_read_new", 32'(rgb), 32'h00FF00);

    // Mid-frame reset, held for three edges.
    run_to(706);
    chk("mid_fb_addr", 32'(fb_addr), 32'd21);
    chk("mid_blank_n", 32'(oBLANK_n), 32'd1);
    chk("mid_rgb", 32'(rgb), 32'h12ED12);
    reset = 1'b1;
    tick();
    chk_reset_state("midrst");
    tick();
    tick();
    reset = 1'b0;
    t = -1;
    run_to(0);
    chk("rel_fb_addr", 32'(fb_addr), 32'd0);
    chk("rel_rd_en", 32'(fb_rd_en), 32'd1);
    run_to(4); chk("rel_frame_pre", 32'(oFrame), 32'd0);
    run_to(5); chk("rel_frame_pulse", 32'(oFrame), 32'd1);

    // Every pixel reads white entry 0; blanked pixels must still be black.
    idx_zero    = 1'b1;
    pal_wr_en   = 1'b1;
    pal_wr_addr = 8'd0;
    pal_wr_data = 24'hFFFFFF;
    tick();
    pal_wr_en = 1'b0;
    run_to(293);
    cnt_vis = 0; cnt_bad = 0; cnt_white = 0;
    while (t <= 580) begin
      if (oBLANK_n) cnt_vis++;
      if (!oBLANK_n && rgb != 24'h0) cnt_bad++;
      if (oBLANK_n && rgb == 24'hFFFFFF) cnt_white++;
      tick();
    end
    chk("blank_rgb_nonzero", 32'(cnt_bad), 32'd0);
    chk("blank_white_pixels", 32'(cnt_white), 32'd128);
    chk("blank_vis_count", 32'(cnt_vis), 32'd128);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
